// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and control-register bit positions.
package int_ctrl_pkg;

  localparam logic [1:0] ADDR_MASK  = 2'd0;
  localparam logic [1:0] ADDR_PEND  = 2'd1;
  localparam logic [1:0] ADDR_VBASE = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  localparam int GIE_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_CALL  = 2'd2,
    ST_INSVC = 2'd3
  } state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// Bundle of IRQ lines, control-unit handshake and config bus for int_ctrl.
// master = control unit / bus host side, slave = the interrupt controller.
interface int_ctrl_if #(
  parameter int NIRQ = 4,
  parameter int DW   = 16
);
  logic [NIRQ-1:0] irq;
  logic            ret;
  logic            jmp;
  logic            call;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [DW-1:0]   cfg_wdata;
  logic [DW-1:0]   cfg_rdata;
  logic            interrupt;
  logic            CallInt;
  logic [DW-1:0]   vector;
  logic [2:0]      active_id;
  logic            in_service;

  modport master (
    output irq, ret, jmp, call, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata, interrupt, CallInt, vector, active_id, in_service
  );

  modport slave (
    input  irq, ret, jmp, call, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata, interrupt, CallInt, vector, active_id, in_service
  );
endinterface

// File: rtl/int_ctrl_irq_sync_edge.sv
// Single IRQ line: SYNC_STAGES-deep synchroniser followed by a history flop;
// rise is high for one cycle when the synchronised level goes 0->1.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic irq_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller feeding the microcode control unit:
// latches IRQ edges as pending, then runs HOLD -> CALL -> INSVC until ret.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NIRQ        = 4,
  parameter int DW          = 16,
  parameter int VSTRIDE     = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic       CLK,
  input logic       RST,
  int_ctrl_if.slave bus
);

  localparam int VSH = $clog2(VSTRIDE);

  logic [NIRQ-1:0] rise, req;
  logic [NIRQ-1:0] mask_q, mask_d, pend_q, pend_d;
  logic [DW-1:0]   vbase_q, vbase_d, vector_q, vector_d, rdata;
  logic            gie_q, gie_d;
  state_e          state_q, state_d;
  logic [2:0]      id_q, id_d, win_id, active_id_q, active_id_d;
  logic            interrupt_q, interrupt_d, callint_q, callint_d;
  logic            in_service_q, in_service_d;
  logic            eligible, wr_pend;

  generate
    for (genvar g = 0; g < NIRQ; g++) begin : g_sync
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK    (CLK),
        .RST    (RST),
        .irq_in (bus.irq[g]),
        .rise   (rise[g])
      );
    end
  endgenerate

  assign req      = pend_q & mask_q;
  assign eligible = gie_q & (|req) & ~bus.jmp & ~bus.call;
  assign wr_pend  = bus.cfg_we && (bus.cfg_addr == ADDR_PEND);

  // Lowest index wins: scan downward so the last match is the lowest one.
  always_comb begin
    win_id = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (req[i]) win_id = 3'(i);
  end

  always_comb begin
    mask_d  = mask_q;
    vbase_d = vbase_q;
    gie_d   = gie_q;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        ADDR_MASK:  mask_d  = bus.cfg_wdata[NIRQ-1:0];
        ADDR_VBASE: vbase_d = bus.cfg_wdata;
        ADDR_CTRL:  gie_d   = bus.cfg_wdata[GIE_BIT];
        default:    ;
      endcase
    end
    // Set after clear so a fresh edge beats both W1C and service clear.
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_d & ~bus.cfg_wdata[NIRQ-1:0];
    if (state_q == ST_CALL) pend_d = pend_d & ~(NIRQ'(1) << id_q);
    pend_d = pend_d | rise;
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    interrupt_d  = 1'b0;
    callint_d    = 1'b0;
    vector_d     = '0;
    in_service_d = in_service_q;
    active_id_d  = active_id_q;
    case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          state_d     = ST_HOLD;
          id_d        = win_id;
          interrupt_d = 1'b1;
        end
      end
      ST_HOLD: begin
        state_d     = ST_CALL;
        interrupt_d = 1'b1;
        callint_d   = 1'b1;
        vector_d    = vbase_q + (DW'(id_q) << VSH);
      end
      ST_CALL: begin
        state_d      = ST_INSVC;
        in_service_d = 1'b1;
        active_id_d  = id_q;
      end
      ST_INSVC: begin
        if (bus.ret) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
          active_id_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q       <= '0;
      pend_q       <= '0;
      vbase_q      <= '0;
      gie_q        <= 1'b0;
      state_q      <= ST_IDLE;
      id_q         <= '0;
      interrupt_q  <= 1'b0;
      callint_q    <= 1'b0;
      vector_q     <= '0;
      in_service_q <= 1'b0;
      active_id_q  <= '0;
    end else begin
      mask_q       <= mask_d;
      pend_q       <= pend_d;
      vbase_q      <= vbase_d;
      gie_q        <= gie_d;
      state_q      <= state_d;
      id_q         <= id_d;
      interrupt_q  <= interrupt_d;
      callint_q    <= callint_d;
      vector_q     <= vector_d;
      in_service_q <= in_service_d;
      active_id_q  <= active_id_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.cfg_addr)
      ADDR_MASK:  rdata[NIRQ-1:0] = mask_q;
      ADDR_PEND:  rdata[NIRQ-1:0] = pend_q;
      ADDR_VBASE: rdata           = vbase_q;
      ADDR_CTRL:  rdata[GIE_BIT]  = gie_q;
      default:    rdata           = '0;
    endcase
  end

  assign bus.cfg_rdata  = rdata;
  assign bus.interrupt  = interrupt_q;
  assign bus.CallInt    = callint_q;
  assign bus.vector     = vector_q;
  assign bus.active_id  = active_id_q;
  assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus a random phase, all checked
// every cycle against a timestamp-based behavioural model.
module tb_int_ctrl;

  localparam int NIRQ = 4;
  localparam int DW   = 16;
  localparam int VST  = 4;
  localparam int S    = 2;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  int_ctrl_if #(.NIRQ(NIRQ), .DW(DW)) bus ();

  int_ctrl #(.NIRQ(NIRQ), .DW(DW), .VSTRIDE(VST), .SYNC_STAGES(S)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Model: registers, an irq delay line, and the cycle the current ISR
  // sequence began (-1 when none); outputs follow from cycles elapsed.
  logic [NIRQ-1:0] m_mask, m_pend;
  logic [DW-1:0]   m_vbase, m_vec;
  logic            m_gie;
  logic [NIRQ-1:0] dly [0:S];
  int              seq_start, cyc, m_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_vbase = '0; m_gie = 1'b0; m_vec = '0;
    for (int k = 0; k <= S; k++) dly[k] = '0;
    seq_start = -1; cyc = 0; m_id = 0;
  endtask

  function automatic int lowest(input logic [NIRQ-1:0] v);
    for (int i = 0; i < NIRQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    int              pd;
    logic [NIRQ-1:0] rise, np;
    logic            elig;
    pd   = (seq_start >= 0) ? cyc - seq_start : -1;
    rise = dly[S-1] & ~dly[S];
    for (int k = S; k > 0; k--) dly[k] = dly[k-1];
    dly[0] = bus.irq;
    elig = m_gie && ((m_pend & m_mask) != 0) && !bus.jmp && !bus.call;
    np = m_pend;
    if (bus.cfg_we && bus.cfg_addr == 2'd1) np = np & ~bus.cfg_wdata[NIRQ-1:0];
    if (pd == 1) np[m_id] = 1'b0;
    np = np | rise;
    cyc++;
    if (pd < 0) begin
      if (elig) begin seq_start = cyc; m_id = lowest(m_pend & m_mask); end
    end else if (pd == 0) m_vec = m_vbase + DW'(m_id * VST);
    else if (pd >= 2 && bus.ret) seq_start = -1;
    if (bus.cfg_we) begin
      if (bus.cfg_addr == 2'd0) m_mask  = bus.cfg_wdata[NIRQ-1:0];
      if (bus.cfg_addr == 2'd2) m_vbase = bus.cfg_wdata;
      if (bus.cfg_addr == 2'd3) m_gie   = bus.cfg_wdata[0];
    end
    m_pend = np;
  endtask

  task automatic check_all();
    int          d;
    logic        busy;
    logic [31:0] erd;
    busy = seq_start >= 0;
    d    = cyc - seq_start;
    chk("interrupt",  32'(bus.interrupt),  32'(busy && d <= 1));
    chk("CallInt",    32'(bus.CallInt),    32'(busy && d == 1));
    chk("vector",     32'(bus.vector),     (busy && d == 1) ? 32'(m_vec) : 32'd0);
    chk("in_service", 32'(bus.in_service), 32'(busy && d >= 2));
    chk("active_id",  32'(bus.active_id),  (busy && d >= 2) ? 32'(m_id) : 32'd0);
    case (bus.cfg_addr)
      2'd0:    erd = 32'(m_mask);
      2'd1:    erd = 32'(m_pend);
      2'd2:    erd = 32'(m_vbase);
      default: erd = 32'(m_gie);
    endcase
    chk("cfg_rdata", 32'(bus.cfg_rdata), erd);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [DW-1:0] v);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = v;
    tick();
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd1;
  endtask

  task automatic wait_callint();
    for (int i = 0; i < 20 && !bus.CallInt; i++) tick();
    chk("callint_seen", 32'(bus.CallInt), 32'd1);
  endtask

  task automatic do_ret();
    bus.ret = 1'b1; tick(); bus.ret = 1'b0; tick();
  endtask

  initial begin
    RST = 1'b1;
    bus.irq = '0; bus.ret = 0; bus.jmp = 0; bus.call = 0;
    bus.cfg_we = 0; bus.cfg_addr = 2'd1; bus.cfg_wdata = '0;
    model_reset();
    #2;
    check_all();
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;

    // Basic entry on irq[0]
    cfg_write(2'd0, 16'h0001);
    cfg_write(2'd2, 16'h0100);
    cfg_write(2'd3, 16'h0001);
    bus.irq = 4'b0001; tick();
    bus.irq = 4'b0000; tick();
    tick();
    chk("pend_after_3_edges", 32'(bus.cfg_rdata), 32'h1);
    tick();
    chk("hold_int", 32'(bus.interrupt), 32'd1);
    chk("hold_ci",  32'(bus.CallInt),   32'd0);
    tick();
    chk("call_ci",  32'(bus.CallInt),   32'd1);
    chk("call_vec", 32'(bus.vector),    32'h0100);
    tick();
    chk("insvc",    32'(bus.in_service), 32'd1);
    chk("pend_clr", 32'(bus.cfg_rdata),  32'h0);
    do_ret();

    // Priority: irq[2] and irq[1] together
    cfg_write(2'd0, 16'h000F);
    bus.irq = 4'b0110;
    wait_callint();
    chk("prio_first", 32'(bus.vector), 32'h0104);
    tick(); tick();
    bus.ret = 1'b1; tick(); bus.ret = 1'b0;
    tick(); tick();
    chk("prio_second", 32'(bus.vector), 32'h0108);
    tick(); do_ret();
    bus.irq = '0;

    // Deferral: GIE off, then jmp held while GIE comes back
    cfg_write(2'd3, 16'h0000);
    bus.irq = 4'b1000;
    repeat (5) tick();
    chk("pend3_no_gie", 32'(bus.cfg_rdata), 32'h8);
    bus.jmp = 1'b1;
    cfg_write(2'd3, 16'h0001);
    repeat (3) tick();
    bus.jmp = 1'b0;
    tick();
    chk("hold_after_jmp", 32'(bus.interrupt), 32'd1);
    tick(); tick(); do_ret();
    bus.irq = '0;

    // W1C racing a fresh edge on irq[1]
    cfg_write(2'd3, 16'h0000);
    bus.irq = 4'b0010; tick(); tick();
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_wdata = 16'h0002;
    tick();
    bus.cfg_we = 1'b0;
    chk("w1c_race_keeps", 32'(bus.cfg_rdata), 32'h2);
    cfg_write(2'd1, 16'h0002);
    chk("w1c_clears", 32'(bus.cfg_rdata), 32'h0);
    bus.irq = '0;

    // No nesting, then stray ret while idle
    cfg_write(2'd3, 16'h0001);
    bus.irq = 4'b0001; tick(); bus.irq = '0;
    wait_callint();
    tick();
    bus.irq = 4'b0010;
    repeat (8) tick();
    chk("no_nest", 32'(bus.interrupt), 32'd0);
    bus.ret = 1'b1; tick(); bus.ret = 1'b0;
    wait_callint();
    chk("nest_served", 32'(bus.vector), 32'h0104);
    tick(); do_ret();
    bus.irq = '0;
    bus.ret = 1'b1; tick(); bus.ret = 1'b0; tick();
    chk("stray_ret", 32'(bus.in_service), 32'd0);

    // Async reset during CALL
    bus.irq = 4'b0100;
    wait_callint();
    RST = 1'b1;
    #1;
    chk("rst_ci",   32'(bus.CallInt),    32'd0);
    chk("rst_int",  32'(bus.interrupt),  32'd0);
    chk("rst_vec",  32'(bus.vector),     32'd0);
    chk("rst_insv", 32'(bus.in_service), 32'd0);
    model_reset();
    bus.irq = '0;
    @(negedge CLK) RST = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.cfg_addr = 2'(a); #1;
      chk("rst_reg", 32'(bus.cfg_rdata), 32'd0);
    end
    bus.cfg_addr = 2'd1;

    // Random phase
    cfg_write(2'd2, 16'hFFF8);
    cfg_write(2'd0, 16'h000F);
    cfg_write(2'd3, 16'h0001);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 5) == 0) bus.irq[$urandom_range(0, NIRQ-1)] ^= 1'b1;
      bus.ret  = ($urandom_range(0, 5) == 0);
      bus.jmp  = ($urandom_range(0, 7) == 0);
      bus.call = ($urandom_range(0, 7) == 0);
      bus.cfg_we    = ($urandom_range(0, 11) == 0);
      bus.cfg_addr  = 2'($urandom_range(0, 3));
      bus.cfg_wdata = 16'($urandom);
      if (bus.cfg_addr == 2'd3 && $urandom_range(0, 3) != 0) bus.cfg_wdata[0] = 1'b1;
      if (bus.cfg_addr == 2'd0 && $urandom_range(0, 1) != 0) bus.cfg_wdata[3:0] = 4'hF;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
